// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the CPU decode/hilo path and the multiply/divide sequencer.
// master drives the instruction side; slave is the sequencer.
interface muldiv_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        stall;
    logic        busy;
    logic        hilo_wr_en;
    logic [63:0] hilo_wr_data;

    modport master (
        output start, op, rs, rt,
        input  stall, busy, hilo_wr_en, hilo_wr_data
    );

    modport slave (
        input  start, op, rs, rt,
        output stall, busy, hilo_wr_en, hilo_wr_data
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer feeding the 64-bit hilo register.
// Optional MULDIV_FAST_MULT_EN replaces the shift-add multiply with a single-cycle product.
module muldiv_sequencer (
    input logic               clk_cpu,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic        is_div_q;
    logic        sign_a_q;
    logic        sign_b_q;
    logic [31:0] a_mag_q;
    logic [31:0] b_mag_q;
    logic [63:0] work_q;
    logic [63:0] result_q;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    // Operand capture: signed only for MULT/DIV (op[0] = 0)
    logic        sign_a_in;
    logic        sign_b_in;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;

    always_comb begin
        sign_a_in = ~bus.op[0] & bus.rs[31];
        sign_b_in = ~bus.op[0] & bus.rt[31];
        a_mag_in  = sign_a_in ? neg32(bus.rs) : bus.rs;
        b_mag_in  = sign_b_in ? neg32(bus.rt) : bus.rt;
    end

`ifdef MULDIV_FAST_MULT_EN
    // Low 64 bits of an extended product are correct for both signed and unsigned
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] fast_prod;

    always_comb begin
        ext_a     = {{32{~bus.op[0] & bus.rs[31]}}, bus.rs};
        ext_b     = {{32{~bus.op[0] & bus.rt[31]}}, bus.rt};
        fast_prod = ext_a * ext_b;
    end
`endif

    // Multiply: work = {partial, multiplier}; add when LSB set, then shift right
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, a_mag_q} : 33'd0);
        mul_next = {mul_sum, work_q[31:1]};
    end

    // Restoring divide: work = {remainder, dividend/quotient}
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;

    always_comb begin
        div_shift = {work_q[63:32], work_q[31]};
        div_ge    = div_shift >= {1'b0, b_mag_q};
        div_diff  = div_shift[31:0] - b_mag_q;
        div_next  = div_ge ? {div_diff, work_q[30:0], 1'b1}
                           : {div_shift[31:0], work_q[30:0], 1'b0};
    end

    logic [63:0] fix_result;

    always_comb begin
        fix_result = work_q;
        if (is_div_q) begin
            if (b_mag_q == 32'd0) begin
                // Divide by zero returns the raw dividend in hi
                fix_result = {sign_a_q ? neg32(a_mag_q) : a_mag_q, 32'hFFFF_FFFF};
            end else begin
                fix_result[31:0]  = (sign_a_q ^ sign_b_q) ? neg32(work_q[31:0]) : work_q[31:0];
                fix_result[63:32] = sign_a_q ? neg32(work_q[63:32]) : work_q[63:32];
            end
        end else if (sign_a_q ^ sign_b_q) begin
            fix_result = ~work_q + 64'd1;
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_mag_q  <= 32'd0;
            b_mag_q  <= 32'd0;
            work_q   <= 64'd0;
            result_q <= 64'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        cnt_q    <= 5'd0;
                        is_div_q <= bus.op[1];
                        sign_a_q <= sign_a_in;
                        sign_b_q <= sign_b_in;
                        a_mag_q  <= a_mag_in;
                        b_mag_q  <= b_mag_in;
                        if (bus.op[1]) begin
                            work_q  <= {32'd0, a_mag_in};
                            state_q <= StDiv;
                        end else begin
`ifdef MULDIV_FAST_MULT_EN
                            result_q <= fast_prod;
                            state_q  <= StDone;
`else
                            work_q  <= {32'd0, b_mag_in};
                            state_q <= StMul;
`endif
                        end
                    end
                end
                StMul: begin
                    work_q <= mul_next;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= StFix;
                end
                StDiv: begin
                    work_q <= div_next;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= StFix;
                end
                StFix: begin
                    result_q <= fix_result;
                    state_q  <= StDone;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.stall        = ((state_q == StIdle) && bus.start) || (state_q == StMul) ||
                           (state_q == StDiv) || (state_q == StFix);
        bus.busy         = (state_q != StIdle);
        bus.hilo_wr_en   = (state_q == StDone);
        bus.hilo_wr_data = result_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: random and directed ops against an arithmetic model.
module tb_muldiv_sequencer;

    logic clk_cpu = 1'b0;
    logic reset   = 1'b0;

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .clk_cpu (clk_cpu),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_cpu = ~clk_cpu;

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] sa;
        logic [63:0] sb;
        int          ia;
        int          ib;
        logic [31:0] q;
        logic [31:0] r;
        case (op)
            2'b00: begin
                sa = {{32{a[31]}}, a};
                sb = {{32{b[31]}}, b};
                return sa * sb;
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                ia = a;
                ib = b;
                q  = ia / ib;
                r  = ia % ib;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // One instruction: start held through DONE, dropped in the cycle after
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int stalls;
        int exp_lat;
        bit seen;
        exp_lat = 34;
`ifdef MULDIV_FAST_MULT_EN
        if (!op[1]) exp_lat = 1;
`endif
        @(negedge clk_cpu);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs    = a;
        bus.rt    = b;
        exp_q.push_back(model(op, a, b));
        stalls = 0;
        seen   = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            #1;
            if (bus.hilo_wr_en) begin
                seen = 1'b1;
                check("stall_low_in_done", 64'(bus.stall), 64'd0);
            end else begin
                if (bus.stall) stalls++;
                @(negedge clk_cpu);
            end
        end
        check("done_reached", 64'(seen), 64'd1);
        check("stall_cycles", 64'(stalls), 64'(exp_lat));
        @(negedge clk_cpu);
        bus.start = 1'b0;
        #1;
        check("busy_after_done", 64'(bus.busy), 64'd0);
        check("no_retrigger_wr", 64'(bus.hilo_wr_en), 64'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.rs    = 32'd0;
        bus.rt    = 32'd0;

        fork
            begin : monitor
                logic [63:0] e;
                forever begin
                    @(negedge clk_cpu);
                    if (bus.hilo_wr_en) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_wr_en", 64'(bus.hilo_wr_en), 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("hilo_wr_data", bus.hilo_wr_data, e);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk_cpu);
        reset = 1'b1;
        #1;
        check("reset_stall", 64'(bus.stall), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_wr_en", 64'(bus.hilo_wr_en), 64'd0);
        check("reset_data", bus.hilo_wr_data, 64'd0);

        // Directed cases
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(2'b00, 32'hFFFF_FFFD, 32'd5);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'b11, 32'd100, 32'd0);
        do_op(2'b10, 32'hFFFF_FF9C, 32'd0);
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000);

        // Reset in C10 of a DIVU aborts without a write
        @(negedge clk_cpu);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.rs    = 32'd12345;
        bus.rt    = 32'd7;
        repeat (10) @(negedge clk_cpu);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk_cpu);
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_stall", 64'(bus.stall), 64'd0);
        check("abort_wr_en", 64'(bus.hilo_wr_en), 64'd0);
        check("abort_data", bus.hilo_wr_data, 64'd0);
        reset = 1'b1;
        repeat (40) @(negedge clk_cpu);

        // Randomized ops, biased toward the divide corner cases
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          mode;
            op   = 2'($urandom_range(0, 3));
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 7);
            if (mode == 0) b = 32'd0;
            else if (mode == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (mode == 2) begin
                a = 32'($urandom_range(0, 1000));
                b = 32'($urandom_range(1, 20));
            end else if (mode == 3) begin
                b = 32'(-int'($urandom_range(1, 50)));
            end
            do_op(op, a, b);
        end

        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk_cpu);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
